// File: rtl/column_drop_ctrl.sv
// Score 4 board-update engine: takes one column request per handshake, drops the
// current player's token into the lowest free cell and reports the outcome.
module column_drop_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int RW   = $clog2(ROWS),
  parameter int MW   = $clog2(COLS*ROWS+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      play_valid,
  input  logic [COLS-1:0]           play,
  output logic                      play_ready,
  output logic [COLS*ROWS*2-1:0]    panel,
  output logic                      turn,
  output logic                      done_valid,
  output logic [1:0]                done_err,
  output logic [$clog2(COLS)-1:0]   done_col,
  output logic [RW-1:0]             done_row,
  output logic [MW-1:0]             moves,
  output logic                      board_full
);
  localparam int CW = $clog2(COLS);
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_REQ  = 2'b01;
  localparam logic [1:0] ERR_FULL = 2'b10;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_nxt;

  logic [COLS-1:0] play_q;
  logic [1:0]      err_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;

  logic            scan_found;
  logic [1:0]      scan_err;
  logic [CW-1:0]   scan_col;
  logic [RW-1:0]   scan_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    play_ready = 1'b0;
    case (state)
      IDLE: begin
        play_ready = !clear;
        if (play_valid && !clear) state_nxt = SCAN;
      end
      SCAN:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Column decode and bottom-up search for the first empty cell; 11 counts as occupied.
  always_comb begin
    scan_col   = '0;
    scan_row   = '0;
    scan_found = 1'b0;
    scan_err   = ERR_OK;
    for (int c = 0; c < COLS; c++) begin
      if (play_q[c]) scan_col = CW'(c);
    end
    for (int r = ROWS-1; r >= 0; r--) begin
      if (!scan_found && panel[(int'(scan_col)*ROWS + r)*2 +: 2] == 2'b00) begin
        scan_found = 1'b1;
        scan_row   = RW'(r);
      end
    end
    if (!$onehot(play_q)) begin
      scan_err = ERR_REQ;
      scan_col = '0;
      scan_row = '0;
    end else if (!scan_found) begin
      scan_err = ERR_FULL;
      scan_row = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_q     <= '0;
      err_q      <= ERR_OK;
      col_q      <= '0;
      row_q      <= '0;
      panel      <= '0;
      turn       <= 1'b0;
      moves      <= '0;
      done_valid <= 1'b0;
      done_err   <= ERR_OK;
      done_col   <= '0;
      done_row   <= '0;
    end else begin
      done_valid <= 1'b0;
      if (clear) begin
        panel <= '0;
        turn  <= 1'b0;
        moves <= '0;
      end else begin
        case (state)
          // accept: capture the request
          IDLE: if (play_valid) play_q <= play;
          // scan: register the lookup result
          SCAN: begin
            err_q <= scan_err;
            col_q <= scan_col;
            row_q <= scan_row;
          end
          // commit: write token on a legal move, always report
          COMMIT: begin
            if (err_q == ERR_OK) begin
              panel[(int'(col_q)*ROWS + int'(row_q))*2 +: 2] <= turn ? 2'b10 : 2'b01;
              turn  <= ~turn;
              moves <= moves + MW'(1);
            end
            done_valid <= 1'b1;
            done_err   <= err_q;
            done_col   <= col_q;
            done_row   <= row_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign board_full = (moves == MW'(COLS*ROWS));

endmodule

// File: tb/tb_column_drop_ctrl.sv
// Bench for column_drop_ctrl: a 7x6 and a 4x4 instance checked every cycle against
// a column-height game model, with literal checkpoints at scripted moments.
module tb_column_drop_ctrl;
  localparam int AC = 7, AR = 6, BC = 4, BR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            clear_a, pv_a, ready_a, turn_a, dv_a, full_a;
  logic [AC-1:0]   pl_a;
  logic [AC*AR*2-1:0] panel_a;
  logic [1:0]      derr_a;
  logic [2:0]      dcol_a, drow_a;
  logic [5:0]      moves_a;

  logic            clear_b, pv_b, ready_b, turn_b, dv_b, full_b;
  logic [BC-1:0]   pl_b;
  logic [BC*BR*2-1:0] panel_b;
  logic [1:0]      derr_b, dcol_b, drow_b;
  logic [4:0]      moves_b;

  int errors = 0;
  int checks = 0;
  int pin_id = 0;

  column_drop_ctrl #(.COLS(AC), .ROWS(AR)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .play_valid(pv_a), .play(pl_a),
    .play_ready(ready_a), .panel(panel_a), .turn(turn_a), .done_valid(dv_a),
    .done_err(derr_a), .done_col(dcol_a), .done_row(drow_a), .moves(moves_a),
    .board_full(full_a));

  column_drop_ctrl #(.COLS(BC), .ROWS(BR)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .play_valid(pv_b), .play(pl_b),
    .play_ready(ready_b), .panel(panel_b), .turn(turn_b), .done_valid(dv_b),
    .done_err(derr_b), .done_col(dcol_b), .done_row(drow_b), .moves(moves_b),
    .board_full(full_b));

  // Game model: each column is a stack of tokens; a request is resolved when it is
  // accepted and takes effect two edges later unless a clear intervenes.
  int mh   [2][8];
  int mtok [2][8][8];
  int mturn [2];
  int mmoves[2];
  int mbusy [2];
  bit mdone [2];
  int perr[2], pcol[2], prow[2];

  function automatic int ncols(int i); return (i == 0) ? AC : BC; endfunction
  function automatic int nrows(int i); return (i == 0) ? AR : BR; endfunction

  function automatic void model_clear(int i);
    for (int c = 0; c < 8; c++) mh[i][c] = 0;
    mturn[i] = 0; mmoves[i] = 0; mbusy[i] = 0; mdone[i] = 1'b0;
  endfunction

  function automatic void resolve(int i, logic [7:0] pl);
    int c;
    c = 0;
    perr[i] = 0; pcol[i] = 0; prow[i] = 0;
    if ($countones(pl) != 1) begin
      perr[i] = 1;
      return;
    end
    for (int k = 0; k < 8; k++) if (pl[k]) c = k;
    pcol[i] = c;
    if (mh[i][c] >= nrows(i)) perr[i] = 2;
    else prow[i] = nrows(i) - 1 - mh[i][c];
  endfunction

  function automatic void step(int i, logic cl, logic pv, logic [7:0] pl);
    mdone[i] = 1'b0;
    if (cl) model_clear(i);
    else if (mbusy[i] == 2) mbusy[i] = 1;
    else if (mbusy[i] == 1) begin
      if (perr[i] == 0) begin
        mtok[i][pcol[i]][mh[i][pcol[i]]] = mturn[i] + 1;
        mh[i][pcol[i]]++;
        mturn[i] ^= 1;
        mmoves[i]++;
      end
      mdone[i] = 1'b1;
      mbusy[i] = 0;
    end else if (pv) begin
      resolve(i, pl);
      mbusy[i] = 2;
    end
  endfunction

  function automatic logic [127:0] mpack(int i);
    logic [127:0] p;
    p = '0;
    for (int c = 0; c < ncols(i); c++)
      for (int h = 0; h < mh[i][c]; h++)
        p[(c*nrows(i) + nrows(i) - 1 - h)*2 +: 2] = 2'(mtok[i][c][h]);
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      step(0, clear_a, pv_a, {1'b0, pl_a});
      step(1, clear_b, pv_b, {4'b0, pl_b});
    end
  end

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void cmp_inst(int i, string tag, logic [127:0] pan, logic tn,
                                   logic [7:0] mv, logic fl, logic rdy, logic cl,
                                   logic dv, logic [1:0] er, logic [2:0] dc, logic [2:0] dr);
    chk({tag, ".panel"}, pan, mpack(i));
    chk({tag, ".turn"}, 128'(tn), 128'(mturn[i]));
    chk({tag, ".moves"}, 128'(mv), 128'(mmoves[i]));
    chk({tag, ".board_full"}, 128'(fl), 128'(mmoves[i] == ncols(i)*nrows(i)));
    chk({tag, ".play_ready"}, 128'(rdy), 128'(mbusy[i] == 0 && !cl));
    chk({tag, ".done_valid"}, 128'(dv), 128'(mdone[i]));
    if (mdone[i]) begin
      chk({tag, ".done_err"}, 128'(er), 128'(perr[i]));
      chk({tag, ".done_col"}, 128'(dc), 128'(pcol[i]));
      chk({tag, ".done_row"}, 128'(dr), 128'(prow[i]));
    end
  endfunction

  always @(negedge clk) begin
    cmp_inst(0, "A", 128'(panel_a), turn_a, 8'(moves_a), full_a, ready_a, clear_a,
             dv_a, derr_a, dcol_a, drow_a);
    cmp_inst(1, "B", 128'(panel_b), turn_b, 8'(moves_b), full_b, ready_b, clear_b,
             dv_b, derr_b, 3'(dcol_b), 3'(drow_b));
    if (pin_id >= 2 && pin_id <= 6) begin
      chk("col1_dv", 128'(dv_a), 128'(1));
      chk("col1_err", 128'(derr_a), 128'(0));
      chk("col1_col", 128'(dcol_a), 128'(1));
      chk("col1_row", 128'(drow_a), 128'(6 - pin_id));
      chk("col1_cell", 128'(panel_a[(6 + 6 - pin_id)*2 +: 2]), 128'((pin_id % 2 == 0) ? 2 : 1));
      chk("col1_moves", 128'(moves_a), 128'(pin_id));
    end
    case (pin_id)
      30: begin
        chk("rst_panel", 128'(panel_a), 128'(0));
        chk("rst_turn", 128'(turn_a), 128'(0));
        chk("rst_moves", 128'(moves_a), 128'(0));
        chk("rst_dv", 128'(dv_a), 128'(0));
        chk("rst_ready", 128'(ready_a), 128'(1));
      end
      1: begin
        chk("first_dv", 128'(dv_a), 128'(1));
        chk("first_err", 128'(derr_a), 128'(0));
        chk("first_col", 128'(dcol_a), 128'(1));
        chk("first_row", 128'(drow_a), 128'(5));
        chk("first_panel", 128'(panel_a), 128'h40_0000);
        chk("first_turn", 128'(turn_a), 128'(1));
        chk("first_moves", 128'(moves_a), 128'(1));
      end
      7: begin
        chk("full_dv", 128'(dv_a), 128'(1));
        chk("full_err", 128'(derr_a), 128'(2));
        chk("full_col", 128'(dcol_a), 128'(1));
        chk("full_row", 128'(drow_a), 128'(0));
        chk("full_panel", 128'(panel_a), 128'h66_6000);
        chk("full_turn", 128'(turn_a), 128'(0));
        chk("model_moves", 128'(mmoves[0]), 128'(6));
      end
      8, 9: begin
        chk("badreq_err", 128'(derr_a), 128'(1));
        chk("badreq_col", 128'(dcol_a), 128'(0));
        chk("badreq_row", 128'(drow_a), 128'(0));
        chk("badreq_moves", 128'(moves_a), 128'(6));
        chk("badreq_panel", 128'(panel_a), 128'h66_6000);
      end
      10: begin
        chk("col6_err", 128'(derr_a), 128'(0));
        chk("col6_col", 128'(dcol_a), 128'(6));
        chk("col6_row", 128'(drow_a), 128'(5));
        chk("col6_panel", 128'(panel_a), 128'h4_0000_0000_0000_0066_6000);
        chk("col6_turn", 128'(turn_a), 128'(1));
      end
      11: begin
        chk("hold_scan_ready", 128'(ready_a), 128'(0));
        chk("hold_scan_dv", 128'(dv_a), 128'(0));
      end
      13: chk("hold_commit_ready", 128'(ready_a), 128'(0));
      12: begin
        chk("hold_done_ready", 128'(ready_a), 128'(1));
        chk("hold_done_dv", 128'(dv_a), 128'(1));
        chk("hold_done_row", 128'(drow_a), 128'(5));
        chk("hold_done_moves", 128'(moves_a), 128'(8));
      end
      18: begin
        chk("hold_moves", 128'(moves_a), 128'(10));
        chk("hold_col0", 128'(panel_a[11:0]), 128'h980);
      end
      14: begin
        chk("clr_dv", 128'(dv_a), 128'(0));
        chk("clr_panel", 128'(panel_a), 128'(0));
        chk("clr_moves", 128'(moves_a), 128'(0));
        chk("clr_turn", 128'(turn_a), 128'(0));
      end
      15, 19: chk("clr_no_done", 128'(dv_a), 128'(0));
      16: chk("clr_blocks_ready", 128'(ready_a), 128'(0));
      17: begin
        chk("clr_no_accept", 128'(ready_a), 128'(1));
        chk("clr_moves2", 128'(moves_a), 128'(0));
      end
      20: begin
        chk("b_last_row", 128'(drow_b), 128'(0));
        chk("b_last_col", 128'(dcol_b), 128'(3));
        chk("b_moves", 128'(moves_b), 128'(16));
        chk("b_full", 128'(full_b), 128'(1));
        chk("b_panel", 128'(panel_b), 128'hAA55_AA55);
      end
      21: begin
        chk("b_full_dv", 128'(dv_b), 128'(1));
        chk("b_full_err", 128'(derr_b), 128'(2));
        chk("b_full_col", 128'(dcol_b), 128'(2));
        chk("b_full_panel", 128'(panel_b), 128'hAA55_AA55);
      end
      22: chk("b_badreq_err", 128'(derr_b), 128'(1));
      23: begin
        chk("arst_panel", 128'(panel_b), 128'(0));
        chk("arst_moves", 128'(moves_b), 128'(0));
        chk("arst_full", 128'(full_b), 128'(0));
        chk("arst_turn", 128'(turn_b), 128'(0));
        chk("arst_done", 128'({dv_b, derr_b, dcol_b, drow_b}), 128'(0));
        chk("arst_panel_a", 128'(panel_a), 128'(0));
      end
      default: ;
    endcase
  end

  task automatic play(input int i, input logic [7:0] pat, input int pin);
    if (i == 0) begin pv_a = 1'b1; pl_a = pat[6:0]; end
    else begin pv_b = 1'b1; pl_b = pat[3:0]; end
    @(posedge clk); #2;
    pv_a = 1'b0; pv_b = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2 pin_id = pin;
    @(posedge clk); #2 pin_id = 0;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    clear_a = 1'b0; pv_a = 1'b0; pl_a = '0;
    clear_b = 1'b0; pv_b = 1'b0; pl_b = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1; pin_id = 30;
    @(posedge clk); #2 pin_id = 0;

    play(0, 8'b0000010, 1);
    for (int n = 0; n < 5; n++) play(0, 8'b0000010, 2 + n);
    play(0, 8'b0000010, 7);
    play(0, 8'b0000000, 8);
    play(0, 8'b0000011, 9);
    play(0, 8'b1000000, 10);

    pv_a = 1'b1; pl_a = 7'b0000001;
    @(posedge clk); #2 pin_id = 11;
    @(posedge clk); #2 pin_id = 13;
    @(posedge clk); #2 pin_id = 12;
    @(posedge clk); #2 pin_id = 0;
    repeat (5) @(posedge clk);
    #2 pv_a = 1'b0;
    @(posedge clk); #2 pin_id = 18;
    @(posedge clk); #2 pin_id = 0;

    pv_a = 1'b1; pl_a = 7'b0000100;
    @(posedge clk); #2 pv_a = 1'b0; clear_a = 1'b1;
    @(posedge clk); #2 clear_a = 1'b0; pin_id = 14;
    @(posedge clk); #2 pin_id = 15;
    @(posedge clk); #2 pin_id = 16; pv_a = 1'b1; pl_a = 7'b0000001; clear_a = 1'b1;
    @(posedge clk); #2 pv_a = 1'b0; clear_a = 1'b0; pin_id = 17;
    @(posedge clk); #2 pin_id = 0;
    @(posedge clk); #2 pin_id = 19;
    @(posedge clk); #2 pin_id = 0;

    repeat (3000) begin
      r = $urandom_range(0, 15);
      if (r == 0) pl_a = '0;
      else if (r == 1) pl_a = 7'($urandom);
      else if (r < 10) pl_a = 7'(1 << $urandom_range(0, 2));
      else pl_a = 7'(1 << $urandom_range(0, 6));
      pv_a = ($urandom_range(0, 3) != 0);
      clear_a = ($urandom_range(0, 199) == 0);
      @(posedge clk); #2;
    end
    pv_a = 1'b0; clear_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    for (int h = 0; h < 4; h++)
      for (int c = 0; c < 4; c++)
        play(1, 8'(1 << c), (h == 3 && c == 3) ? 20 : 0);
    play(1, 8'b0100, 21);
    play(1, 8'b0011, 22);

    pv_b = 1'b1; pl_b = 4'b0010;
    @(posedge clk); #2 pv_b = 1'b0; rst_n = 1'b0; pin_id = 23;
    @(posedge clk); #2 pin_id = 0; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
